// File: rtl/cache_pkg.sv
// Package: cache_pkg
// Shared definitions for the set-associative cache.
//   cache_state_e : controller states (IDLE, FILL, WRITE, RESP)
//   off_w/idx_w/tag_w : derive the address-field widths from the cache geometry.
//     The byte address splits as {tag, idx, off, byte}; the byte-select bit is ignored.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } cache_state_e;

  function automatic int off_w(input int line_w);
    return $clog2(line_w);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets, input int line_w);
    return addr_w - 1 - $clog2(sets) - $clog2(line_w);
  endfunction

endpackage

// File: rtl/cache_way.sv
// Module: cache_way
// One way of the cache: data array (SETS x LINE_W words), tag array and
// per-set valid bits.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears valid bits only)
//   rd_idx, rd_off      combinational lookup address
//   rd_data, rd_tag,    word, tag and valid bit at the lookup address
//   rd_valid
//   wr_en, wr_idx,      single-word write into the data array
//   wr_off, wr_data
//   tag_we, tag_idx,    line-tag write; also sets the valid bit of that set
//   tag_wdata
//   inv_we              clears the valid bit of set tag_idx (start of a refill)
module cache_way
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  parameter  int SETS   = 128,
  parameter  int LINE_W = 8,
  localparam int OFF_W  = off_w(LINE_W),
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [OFF_W-1:0]  rd_off,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [OFF_W-1:0]  wr_off,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic              inv_we,
  input  logic [IDX_W-1:0]  tag_idx,
  input  logic [TAG_W-1:0]  tag_wdata
);

  logic [DATA_W-1:0] data_q [SETS*LINE_W];
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [SETS-1:0]   valid_q, valid_d;

  assign rd_data  = data_q[{rd_idx, rd_off}];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

  // Storage arrays carry no reset; only the valid bits define cache contents.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[{wr_idx, wr_off}] <= wr_data;
    if (tag_we) tag_q[tag_idx] <= tag_wdata;
  end

  always_comb begin
    valid_d = valid_q;
    if (inv_we) valid_d[tag_idx] = 1'b0;
    if (tag_we) valid_d[tag_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

endmodule

// File: rtl/assoc_cache.sv
// Module: assoc_cache
// Set-associative (1 or 2 ways), write-through, no-write-allocate cache with
// an integrated line-fill engine between the CPU port and backing memory.
// Optional feature macro: CACHE_STATS_EN adds saturating hit_cnt/miss_cnt.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack               load data and one-cycle completion pulse
//   busy                             controller is not IDLE
//   mem_req/we/addr/wdata            memory beat request, held until mem_ack
//   mem_rdata, mem_ack               memory beat completion and read data
//   hit_cnt, miss_cnt                (CACHE_STATS_EN only) access statistics
//
// Handshakes: a requester raises req with its payload and holds both stable
// until the responder's single-cycle ack; the beat completes on the clock edge
// where ack is high. The cache samples cpu_req only in IDLE and not in a cycle
// where cpu_ack is high, so the held request that was just acknowledged is
// never taken twice. mem_req is re-evaluated after every mem_ack.
module assoc_cache
  import cache_pkg::*;
#(
  parameter  int ADDR_W = 16,
  parameter  int DATA_W = 16,
  parameter  int WAYS   = 2,
  parameter  int SETS   = 128,
  parameter  int LINE_W = 8,
  localparam int OFF_W  = off_w(LINE_W),
  localparam int IDX_W  = idx_w(SETS),
  localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  // ---------------- address fields ----------------
  logic [ADDR_W-2:0] cpu_waddr;
  logic [OFF_W-1:0]  cpu_off;
  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic              unused_addr_bit;

  assign cpu_waddr       = cpu_addr[ADDR_W-1:1];
  assign cpu_off         = cpu_waddr[OFF_W-1:0];
  assign cpu_idx         = cpu_waddr[OFF_W+IDX_W-1:OFF_W];
  assign cpu_tag         = cpu_waddr[ADDR_W-2:OFF_W+IDX_W];
  assign unused_addr_bit = cpu_addr[0];

  // ---------------- registers ----------------
  cache_state_e      state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;
  logic              victim_q, victim_d;
  logic [ADDR_W-2:0] req_waddr_q, req_waddr_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  cnt_nxt;

  assign req_off = req_waddr_q[OFF_W-1:0];
  assign req_idx = req_waddr_q[OFF_W+IDX_W-1:OFF_W];
  assign req_tag = req_waddr_q[ADDR_W-2:OFF_W+IDX_W];
  assign cnt_nxt = cnt_q + OFF_W'(1);

  // ---------------- ways ----------------
  logic [WAYS-1:0]   way_valid, way_hit, way_wr_en, way_tag_we, way_inv;
  logic [DATA_W-1:0] way_data [WAYS];
  logic [TAG_W-1:0]  way_tag  [WAYS];

  // Array write controls, driven by the FSM.
  logic              wr_en;
  logic              wr_way;
  logic [IDX_W-1:0]  wr_idx;
  logic [OFF_W-1:0]  wr_off;
  logic [DATA_W-1:0] wr_data;
  logic              tag_we;
  logic              inv_we;
  logic [IDX_W-1:0]  tag_idx;

  // LRU update request, consumed only when WAYS == 2.
  logic              lru_upd;
  logic              lru_way;
  logic [IDX_W-1:0]  lru_idx;

  logic              hit;
  logic              hit_way;
  logic [DATA_W-1:0] hit_data;
  logic              victim_sel;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .SETS   (SETS),
      .LINE_W (LINE_W)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (cpu_idx),
      .rd_off    (cpu_off),
      .rd_data   (way_data[w]),
      .rd_tag    (way_tag[w]),
      .rd_valid  (way_valid[w]),
      .wr_en     (way_wr_en[w]),
      .wr_idx    (wr_idx),
      .wr_off    (wr_off),
      .wr_data   (wr_data),
      .tag_we    (way_tag_we[w]),
      .inv_we    (way_inv[w]),
      .tag_idx   (tag_idx),
      .tag_wdata (req_tag)
    );
    assign way_hit[w]    = way_valid[w] && (way_tag[w] == cpu_tag);
    assign way_wr_en[w]  = wr_en  && (wr_way == 1'(w));
    // Tag write lands in the way latched at fill start; invalidate uses the
    // victim chosen in the same cycle.
    assign way_tag_we[w] = tag_we && (victim_q == 1'(w));
    assign way_inv[w]    = inv_we && (victim_sel == 1'(w));
  end

  assign hit = |way_hit;

  if (WAYS == 2) begin : g_lru
    // lru_q[set] names the way NOT most recently accessed in that set.
    logic [SETS-1:0] lru_q, lru_d;

    always_comb begin
      lru_d = lru_q;
      if (lru_upd) lru_d[lru_idx] = ~lru_way;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lru_q <= '0;
      else        lru_q <= lru_d;
    end

    assign hit_way    = way_hit[1];
    assign hit_data   = way_hit[1] ? way_data[1] : way_data[0];
    // Prefer an empty way (way 0 first) before evicting.
    assign victim_sel = !way_valid[0] ? 1'b0 :
                        !way_valid[1] ? 1'b1 : lru_q[cpu_idx];
  end else begin : g_one_way
    logic unused_lru;
    assign unused_lru = lru_upd ^ lru_way ^ (^lru_idx);
    assign hit_way    = 1'b0;
    assign hit_data   = way_data[0];
    assign victim_sel = 1'b0;
  end

  // ---------------- controller ----------------
  logic sample;
  assign sample = (state_q == IDLE) && cpu_req && !cpu_ack_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    victim_d    = victim_q;
    req_waddr_d = req_waddr_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_way      = hit_way;
    wr_idx      = cpu_idx;
    wr_off      = cpu_off;
    wr_data     = cpu_wdata;
    tag_we      = 1'b0;
    inv_we      = 1'b0;
    tag_idx     = cpu_idx;
    lru_upd     = 1'b0;
    lru_way     = hit_way;
    lru_idx     = cpu_idx;

    case (state_q)
      IDLE: begin
        if (sample) begin
          req_waddr_d = cpu_waddr;
          if (cpu_we) begin
            // Write-through: update a hit line now, always forward to memory.
            if (hit) begin
              wr_en   = 1'b1;
              lru_upd = 1'b1;
            end
            state_d     = WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {cpu_waddr, 1'b0};
            mem_wdata_d = cpu_wdata;
          end else if (hit) begin
            lru_upd     = 1'b1;
            cpu_rdata_d = hit_data;
            cpu_ack_d   = 1'b1;
            state_d     = RESP;
          end else begin
            // Invalidate the victim up front so its stale tag can never match
            // a line whose data is half overwritten.
            victim_d   = victim_sel;
            inv_we     = 1'b1;
            cnt_d      = '0;
            state_d    = FILL;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {cpu_tag, cpu_idx, {OFF_W{1'b0}}, 1'b0};
          end
        end
      end

      FILL: begin
        if (mem_ack) begin
          wr_en   = 1'b1;
          wr_way  = victim_q;
          wr_idx  = req_idx;
          wr_off  = cnt_q;
          wr_data = mem_rdata;
          if (cnt_q == req_off) cpu_rdata_d = mem_rdata;
          if (cnt_q == OFF_W'(LINE_W - 1)) begin
            tag_we    = 1'b1;
            tag_idx   = req_idx;
            lru_upd   = 1'b1;
            lru_way   = victim_q;
            lru_idx   = req_idx;
            mem_req_d = 1'b0;
            cnt_d     = '0;
            cpu_ack_d = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d      = cnt_nxt;
            mem_addr_d = {req_tag, req_idx, cnt_nxt, 1'b0};
          end
        end
      end

      WRITE: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          state_d   = IDLE;
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      victim_q    <= 1'b0;
      req_waddr_q <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      victim_q    <= victim_d;
      req_waddr_q <= req_waddr_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign busy      = busy_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_STATS_EN
  // ---------------- statistics ----------------
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (sample && hit && !(&hit_cnt_q))   hit_cnt_d  = hit_cnt_q + 32'd1;
    if (sample && !hit && !(&miss_cnt_q)) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Testbench: tb_assoc_cache
// Directed, table-driven bench for assoc_cache (default geometry: 16-bit
// addresses, 2 ways, 128 sets, 8-word lines). A behavioural memory answers
// each mem_req beat on the falling edge; unwritten words read as
// 0xA000 + word-offset-in-line, written words return the stored value.
module tb_assoc_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, busy;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  assoc_cache dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [15:0] mem_arr [logic [15:0]];
  int          rd_beats = 0;
  int          wr_beats = 0;
  logic [15:0] act_q[$];
  logic [15:0] exp_q[$];

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
  end

  always @(negedge clk) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_req && rst_n) begin
      mem_ack = 1'b1;
      if (mem_we) begin
        mem_arr[mem_addr] = mem_wdata;
        wr_beats++;
      end else begin
        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr]
                                             : 16'hA000 + {13'd0, mem_addr[3:1]};
        rd_beats++;
        act_q.push_back(mem_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the recorded fill-beat addresses against one full line from base.
  task automatic check_fill_addrs(input string name, input logic [15:0] base);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 16'(2 * i));
    check({name, "_beat_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < 8 && i < act_q.size(); i++)
      check($sformatf("%s_beat%0d_addr", name, i), {16'd0, act_q[i]}, {16'd0, exp_q[i]});
  endtask

  task automatic check_stats(input string name);
`ifdef CACHE_STATS_EN
    check({name, "_hit_cnt"}, hit_cnt, exp_hits);
    check({name, "_miss_cnt"}, miss_cnt, exp_misses);
`else
    if (name.len() == 0) $display("empty stats tag");
`endif
  endtask

  // ---------------- driver ----------------
  // Latency counts the sampling cycle plus every cycle up to and including ack.
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output logic [15:0] rdata, output int lat);
    int  n;
    bit  got;
    @(negedge clk);
    rd_beats  = 0;
    wr_beats  = 0;
    act_q.delete();
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_req   = 1'b1;
    n   = 0;
    got = 1'b0;
    rdata = 16'h0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (cpu_ack) begin
        got   = 1'b1;
        rdata = cpu_rdata;
      end
    end
    cpu_req = 1'b0;
    lat = got ? n + 1 : -1;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL ack_timeout: no cpu_ack for addr 0x%0h within 100 cycles", addr);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_rd;
    int          exp_wr;
    int          exp_lat;   // 0 = latency not checked
    bit          exp_hit;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [15:0] rdata;
    int          lat;
    int          n;

    // Load 0x1234: tag 2, set 0x23, word 2.
    vecs[0]  = '{1'b0, 16'h1234, 16'h0,    16'hA002, 8, 0, 17, 1'b0};
    vecs[1]  = '{1'b0, 16'h1234, 16'h0,    16'hA002, 0, 0, 2,  1'b1};
    vecs[2]  = '{1'b0, 16'h1230, 16'h0,    16'hA000, 0, 0, 2,  1'b1};
    vecs[3]  = '{1'b0, 16'h123E, 16'h0,    16'hA007, 0, 0, 2,  1'b1};
    vecs[4]  = '{1'b1, 16'h1234, 16'hBEEF, 16'h0,    0, 1, 0,  1'b1};
    vecs[5]  = '{1'b0, 16'h1234, 16'h0,    16'hBEEF, 0, 0, 2,  1'b1};
    // Store miss: no allocate, the next load refills from memory.
    vecs[6]  = '{1'b1, 16'h4000, 16'h5A5A, 16'h0,    0, 1, 0,  1'b0};
    vecs[7]  = '{1'b0, 16'h4000, 16'h0,    16'h5A5A, 8, 0, 17, 1'b0};
    vecs[8]  = '{1'b0, 16'h4002, 16'h0,    16'hA001, 0, 0, 2,  1'b1};
    // Set 3: tag A=1 (0x083x), B=2 (0x103x), C=3 (0x183x).
    vecs[9]  = '{1'b0, 16'h0830, 16'h0,    16'hA000, 8, 0, 17, 1'b0};
    vecs[10] = '{1'b0, 16'h1032, 16'h0,    16'hA001, 8, 0, 17, 1'b0};
    vecs[11] = '{1'b0, 16'h0834, 16'h0,    16'hA002, 0, 0, 2,  1'b1};
    vecs[12] = '{1'b0, 16'h1836, 16'h0,    16'hA003, 8, 0, 17, 1'b0};
    vecs[13] = '{1'b0, 16'h0830, 16'h0,    16'hA000, 0, 0, 2,  1'b1};
    vecs[14] = '{1'b0, 16'h1830, 16'h0,    16'hA000, 0, 0, 2,  1'b1};
    vecs[15] = '{1'b0, 16'h1030, 16'h0,    16'hA000, 8, 0, 17, 1'b0};

    // ---------------- reset ----------------
    rst_n     = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 16'h0;
    cpu_wdata = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ack",   {31'd0, cpu_ack},   32'd0);
    check("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  {16'd0, mem_addr},  32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check_stats("rst");
    #1 rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < 16; i++) begin
      do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rdata, lat);
      if (vecs[i].exp_hit) exp_hits++;
      else                 exp_misses++;
      if (!vecs[i].we)
        check($sformatf("v%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
      check($sformatf("v%0d_rd_beats", i), rd_beats, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_beats", i), wr_beats, vecs[i].exp_wr);
      if (vecs[i].exp_lat != 0)
        check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_idle_mem_req", i), {31'd0, mem_req}, 32'd0);
      if (i == 0) check_fill_addrs("v0_fill", 16'h1230);
      check_stats($sformatf("v%0d", i));
    end

    // ---------------- reset in the middle of a fill ----------------
    @(negedge clk);
    rd_beats = 0;
    act_q.delete();
    cpu_we   = 1'b0;
    cpu_addr = 16'h2468;
    cpu_req  = 1'b1;
    n = 0;
    while (rd_beats < 4 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_beats_before_reset", rd_beats, 4);
    @(posedge clk);
    #2;
    check("abort_mem_req_before_reset", {31'd0, mem_req}, 32'd1);
    rst_n   = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("abort_mem_req_async", {31'd0, mem_req}, 32'd0);
    check("abort_busy_async",    {31'd0, busy},    32'd0);
    check("abort_cpu_ack",       {31'd0, cpu_ack}, 32'd0);
    exp_hits   = 0;
    exp_misses = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    check_stats("abort_rst");

    // The aborted line must not hit; it refills completely.
    do_access(1'b0, 16'h2468, 16'h0, rdata, lat);
    exp_misses++;
    check("refill_rdata",    {16'd0, rdata}, 32'h0000A004);
    check("refill_rd_beats", rd_beats, 8);
    check("refill_latency",  lat, 17);
    check_fill_addrs("refill", 16'h2460);
    check_stats("refill");

    // Reset cleared every valid bit, so the earlier line misses and memory
    // returns the stored value.
    do_access(1'b0, 16'h1234, 16'h0, rdata, lat);
    exp_misses++;
    check("post_rst_rdata",    {16'd0, rdata}, 32'h0000BEEF);
    check("post_rst_rd_beats", rd_beats, 8);
    do_access(1'b0, 16'h2468, 16'h0, rdata, lat);
    exp_hits++;
    check("refill_hit_rdata", {16'd0, rdata}, 32'h0000A004);
    check("refill_hit_beats", rd_beats, 0);
    check("refill_hit_lat",   lat, 2);
    check_stats("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
